// File: rtl/xpu_sched_pkg.sv
// Shared definitions for the TX queue scheduler.
//   NUM_Q      : number of queues/slices (only 4 supported)
//   QID_W      : width of a queue id
//   CW_EXP_W   : contention-window exponent field width
//   RETRY_W    : retry counter field width
//   TIMEOUT_W  : tx watchdog width (microseconds)
//   sched_state_t : scheduler FSM states
package xpu_sched_pkg;

    localparam int unsigned NUM_Q     = 4;
    localparam int unsigned QID_W     = 2;
    localparam int unsigned CW_EXP_W  = 4;
    localparam int unsigned RETRY_W   = 4;
    localparam int unsigned TIMEOUT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_DONE,
        ST_UPDATE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter.
//   req       : request vector, one bit per queue
//   ptr       : last granted queue; search starts at ptr+1 (mod 4)
//   gnt_id    : selected queue (0 when nothing requested)
//   gnt_valid : at least one request present
module rr_arbiter4
    import xpu_sched_pkg::*;
(
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] ptr,
    output logic [QID_W-1:0] gnt_id,
    output logic             gnt_valid
);

    logic [QID_W-1:0] cand;

    // Walk the queues in priority order; the first requester found wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_Q; k++) begin
            cand = ptr + QID_W'(k + 1);
            if (!gnt_valid && req[cand]) begin
                gnt_id    = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_queue_scheduler.sv
// Per-queue transmit scheduler with CW/retry bookkeeping.
// Grants one eligible queue (round-robin) to the tx engine, waits for the
// end-of-exchange pulse or a microsecond watchdog, then updates that queue's
// contention-window exponent and retry counter.
//   clk, rst          : clock, synchronous active-high reset
//   tsf_pulse_1M      : 1 us tick for the watchdog
//   q_pending         : queue i has a frame ready
//   tx_allowed        : queue i has finished backoff
//   cw_min_exp/max    : configured CW exponent bounds
//   retry_limit       : max retransmissions per frame
//   tx_timeout_us     : watchdog limit (0 disables)
//   tx_done/tx_ack_ok : end-of-exchange pulse and its ACK outcome
//   tx_start/tx_qid   : grant pulse and granted queue
//   cw_exp_all        : packed per-queue CW exponents
//   retry_cnt_all     : packed per-queue retry counts
//   tx_success/drop   : outcome pulses, evt_qid names the queue
//   busy              : scheduler not idle
module tx_queue_scheduler #(
    parameter int unsigned NUM_Q         = xpu_sched_pkg::NUM_Q,
    parameter int unsigned CW_EXP_WIDTH  = xpu_sched_pkg::CW_EXP_W,
    parameter int unsigned RETRY_WIDTH   = xpu_sched_pkg::RETRY_W,
    parameter int unsigned TIMEOUT_WIDTH = xpu_sched_pkg::TIMEOUT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tsf_pulse_1M,
    input  logic [NUM_Q-1:0]                q_pending,
    input  logic [NUM_Q-1:0]                tx_allowed,
    input  logic [CW_EXP_WIDTH-1:0]         cw_min_exp,
    input  logic [CW_EXP_WIDTH-1:0]         cw_max_exp,
    input  logic [RETRY_WIDTH-1:0]          retry_limit,
    input  logic [TIMEOUT_WIDTH-1:0]        tx_timeout_us,
    input  logic                            tx_done,
    input  logic                            tx_ack_ok,
    output logic                            tx_start,
    output logic [1:0]                      tx_qid,
    output logic [NUM_Q*CW_EXP_WIDTH-1:0]   cw_exp_all,
    output logic [NUM_Q*RETRY_WIDTH-1:0]    retry_cnt_all,
    output logic                            tx_success,
    output logic                            tx_drop,
    output logic [1:0]                      evt_qid,
    output logic                            busy
);

    import xpu_sched_pkg::*;

    sched_state_t state, state_next;

    logic [1:0]               last_grant;
    logic                     ack_ok_q;
    logic [TIMEOUT_WIDTH-1:0] watchdog;
    logic [CW_EXP_WIDTH-1:0]  cw_q    [NUM_Q];
    logic [RETRY_WIDTH-1:0]   retry_q [NUM_Q];

    logic [NUM_Q-1:0]         eligible;
    logic [1:0]               arb_id;
    logic                     arb_valid;

    logic [CW_EXP_WIDTH-1:0]  eff_min;
    logic                     wd_expired;

    logic                     grant_take;
    logic                     finish;
    logic                     finish_ack;
    logic                     tx_start_next;
    logic                     busy_next;

    logic [CW_EXP_WIDTH-1:0]  cw_cur;
    logic [CW_EXP_WIDTH:0]    cw_inc;
    logic [CW_EXP_WIDTH-1:0]  cw_fail;
    logic [RETRY_WIDTH-1:0]   retry_cur;
    logic [RETRY_WIDTH:0]     retry_inc;
    logic                     upd_success;
    logic                     upd_drop;
    logic                     upd_backoff;

    assign eligible   = q_pending & tx_allowed;
    assign eff_min    = (cw_min_exp < cw_max_exp) ? cw_min_exp : cw_max_exp;
    assign wd_expired = (tx_timeout_us != '0) && (watchdog == tx_timeout_us);

    rr_arbiter4 u_arb (
        .req       (eligible),
        .ptr       (last_grant),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_next    = state;
        grant_take    = 1'b0;
        finish        = 1'b0;
        finish_ack    = 1'b0;
        tx_start_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_next = ST_GRANT;
                    grant_take = 1'b1;
                end
            end
            ST_GRANT: begin
                state_next    = ST_WAIT_DONE;
                tx_start_next = 1'b1;
            end
            ST_WAIT_DONE: begin
                // tx_done takes precedence over a coincident watchdog expiry
                if (tx_done) begin
                    state_next = ST_UPDATE;
                    finish     = 1'b1;
                    finish_ack = tx_ack_ok;
                end else if (wd_expired) begin
                    state_next = ST_UPDATE;
                    finish     = 1'b1;
                    finish_ack = 1'b0;
                end
            end
            ST_UPDATE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // Outcome decode for the granted queue. Widened adders keep the
    // saturation/limit compares free of wrap-around.
    always_comb begin
        cw_cur      = cw_q[tx_qid];
        retry_cur   = retry_q[tx_qid];
        cw_inc      = {1'b0, cw_cur} + (CW_EXP_WIDTH+1)'(1);
        cw_fail     = (cw_inc > {1'b0, cw_max_exp}) ? cw_max_exp
                                                    : cw_inc[CW_EXP_WIDTH-1:0];
        retry_inc   = {1'b0, retry_cur} + (RETRY_WIDTH+1)'(1);
        upd_success = (state == ST_UPDATE) && ack_ok_q;
        upd_drop    = (state == ST_UPDATE) && !ack_ok_q &&
                      (retry_inc > {1'b0, retry_limit});
        upd_backoff = (state == ST_UPDATE) && !ack_ok_q &&
                      !(retry_inc > {1'b0, retry_limit});
    end

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 2'd3;
            tx_qid     <= '0;
            ack_ok_q   <= 1'b0;
            tx_start   <= 1'b0;
            tx_success <= 1'b0;
            tx_drop    <= 1'b0;
            evt_qid    <= '0;
            busy       <= 1'b0;
            watchdog   <= '0;
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            tx_start   <= tx_start_next;
            tx_success <= upd_success;
            tx_drop    <= upd_drop;
            if (upd_success || upd_drop) begin
                evt_qid <= tx_qid;
            end
            if (grant_take) begin
                tx_qid     <= arb_id;
                last_grant <= arb_id;
            end
            if (finish) begin
                ack_ok_q <= finish_ack;
            end
            if (state == ST_GRANT) begin
                watchdog <= '0;
            end else if ((state == ST_WAIT_DONE) && tsf_pulse_1M) begin
                watchdog <= watchdog + TIMEOUT_WIDTH'(1);
            end
        end
    end

    // Per-queue CW exponent and retry counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_Q; i++) begin
                cw_q[i]    <= eff_min;
                retry_q[i] <= '0;
            end
        end else if (upd_success || upd_drop) begin
            cw_q[tx_qid]    <= eff_min;
            retry_q[tx_qid] <= '0;
        end else if (upd_backoff) begin
            cw_q[tx_qid]    <= cw_fail;
            retry_q[tx_qid] <= retry_inc[RETRY_WIDTH-1:0];
        end
    end

    always_comb begin
        cw_exp_all    = '0;
        retry_cnt_all = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            cw_exp_all[i*CW_EXP_WIDTH +: CW_EXP_WIDTH]   = cw_q[i];
            retry_cnt_all[i*RETRY_WIDTH +: RETRY_WIDTH] = retry_q[i];
        end
    end

endmodule

// File: tb/tb_tx_queue_scheduler.sv
// Directed self-checking bench for tx_queue_scheduler.
module tb_tx_queue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        tsf_pulse_1M;
    logic [3:0]  q_pending;
    logic [3:0]  tx_allowed;
    logic [3:0]  cw_min_exp;
    logic [3:0]  cw_max_exp;
    logic [3:0]  retry_limit;
    logic [11:0] tx_timeout_us;
    logic        tx_done;
    logic        tx_ack_ok;
    logic        tx_start;
    logic [1:0]  tx_qid;
    logic [15:0] cw_exp_all;
    logic [15:0] retry_cnt_all;
    logic        tx_success;
    logic        tx_drop;
    logic [1:0]  evt_qid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    tx_queue_scheduler #(
        .NUM_Q         (4),
        .CW_EXP_WIDTH  (4),
        .RETRY_WIDTH   (4),
        .TIMEOUT_WIDTH (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tsf_pulse_1M  (tsf_pulse_1M),
        .q_pending     (q_pending),
        .tx_allowed    (tx_allowed),
        .cw_min_exp    (cw_min_exp),
        .cw_max_exp    (cw_max_exp),
        .retry_limit   (retry_limit),
        .tx_timeout_us (tx_timeout_us),
        .tx_done       (tx_done),
        .tx_ack_ok     (tx_ack_ok),
        .tx_start      (tx_start),
        .tx_qid        (tx_qid),
        .cw_exp_all    (cw_exp_all),
        .retry_cnt_all (retry_cnt_all),
        .tx_success    (tx_success),
        .tx_drop       (tx_drop),
        .evt_qid       (evt_qid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] mn, input logic [3:0] mx,
                               input logic [3:0] rl, input logic [11:0] to);
        cw_min_exp    = mn;
        cw_max_exp    = mx;
        retry_limit   = rl;
        tx_timeout_us = to;
        q_pending     = '0;
        tx_allowed    = '0;
        tx_done       = 1'b0;
        tx_ack_ok     = 1'b0;
        tsf_pulse_1M  = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Cycles until tx_start is seen, or -1 if it never arrives within the budget.
    task automatic wait_start(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (tx_start === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pulse_done(input logic ack);
        tx_done   = 1'b1;
        tx_ack_ok = ack;
        tick();
        tx_done   = 1'b0;
        tx_ack_ok = 1'b0;
    endtask

    task automatic tsf_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tsf_pulse_1M = 1'b1;
            tick();
            tsf_pulse_1M = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset(4'd4, 4'd10, 4'd7, 12'd0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%0h exp=0", tx_start); end
        total++; if ({tx_success, tx_drop} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%0b exp=00", {tx_success, tx_drop}); end
        total++; if ({tx_qid, evt_qid} !== 4'h0) begin bad++; $display("FAIL reset_qids got=%0h exp=0", {tx_qid, evt_qid}); end
        total++; if (retry_cnt_all !== 16'h0000) begin bad++; $display("FAIL reset_retry got=%h exp=0000", retry_cnt_all); end
        total++; if (cw_exp_all !== 16'h4444) begin bad++; $display("FAIL reset_cw got=%h exp=4444", cw_exp_all); end
    endtask

    task automatic test_round_robin();
        int lat;
        apply_reset(4'd4, 4'd10, 4'd7, 12'd0);
        q_pending  = 4'b1111;
        tx_allowed = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_start(lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL rr_latency[%0d] got=%0d exp=2", i, lat); end
            total++; if (tx_qid !== 2'(i)) begin bad++; $display("FAIL rr_qid[%0d] got=%0d exp=%0d", i, tx_qid, i); end
            pulse_done(1'b1);
            tick();
            total++; if (tx_success !== 1'b1 || tx_drop !== 1'b0) begin bad++; $display("FAIL rr_success[%0d] got=%0b%0b exp=10", i, tx_success, tx_drop); end
            total++; if (evt_qid !== 2'(i)) begin bad++; $display("FAIL rr_evt_qid[%0d] got=%0d exp=%0d", i, evt_qid, i); end
            if (i == 3) q_pending = 4'b0000;
        end
        total++; if (cw_exp_all !== 16'h4444 || retry_cnt_all !== 16'h0000) begin bad++; $display("FAIL rr_counters got=%h/%h exp=4444/0000", cw_exp_all, retry_cnt_all); end
    endtask

    task automatic test_backoff();
        int lat;
        logic [15:0] exp_cw [3];
        logic [15:0] exp_rt [3];
        exp_cw[0] = 16'h4544; exp_cw[1] = 16'h4644; exp_cw[2] = 16'h4644;
        exp_rt[0] = 16'h0100; exp_rt[1] = 16'h0200; exp_rt[2] = 16'h0300;
        apply_reset(4'd4, 4'd6, 4'd7, 12'd0);
        q_pending  = 4'b0100;
        tx_allowed = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            wait_start(lat);
            total++; if (tx_qid !== 2'd2) begin bad++; $display("FAIL bo_qid[%0d] got=%0d exp=2", i, tx_qid); end
            pulse_done(1'b0);
            tick();
            if (i == 2) q_pending = 4'b0000;
            total++; if (cw_exp_all !== exp_cw[i]) begin bad++; $display("FAIL bo_cw[%0d] got=%h exp=%h", i, cw_exp_all, exp_cw[i]); end
            total++; if (retry_cnt_all !== exp_rt[i]) begin bad++; $display("FAIL bo_retry[%0d] got=%h exp=%h", i, retry_cnt_all, exp_rt[i]); end
            total++; if ({tx_success, tx_drop} !== 2'b00) begin bad++; $display("FAIL bo_pulses[%0d] got=%0b exp=00", i, {tx_success, tx_drop}); end
        end
    endtask

    task automatic test_retry_drop();
        int lat;
        logic [15:0] exp_cw [3];
        logic [15:0] exp_rt [3];
        exp_cw[0] = 16'h4454; exp_cw[1] = 16'h4464; exp_cw[2] = 16'h4444;
        exp_rt[0] = 16'h0010; exp_rt[1] = 16'h0020; exp_rt[2] = 16'h0000;
        apply_reset(4'd4, 4'd10, 4'd2, 12'd0);
        q_pending  = 4'b0010;
        tx_allowed = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            wait_start(lat);
            pulse_done(1'b0);
            tick();
            if (i == 2) q_pending = 4'b0000;
            total++; if (tx_drop !== (i == 2)) begin bad++; $display("FAIL drop_pulse[%0d] got=%0b exp=%0b", i, tx_drop, (i == 2)); end
            total++; if (cw_exp_all !== exp_cw[i] || retry_cnt_all !== exp_rt[i]) begin bad++; $display("FAIL drop_counters[%0d] got=%h/%h exp=%h/%h", i, cw_exp_all, retry_cnt_all, exp_cw[i], exp_rt[i]); end
        end
        total++; if (evt_qid !== 2'd1 || tx_success !== 1'b0) begin bad++; $display("FAIL drop_evt got=%0d/%0b exp=1/0", evt_qid, tx_success); end
    endtask

    task automatic test_watchdog();
        int lat;
        apply_reset(4'd4, 4'd10, 4'd7, 12'd5);
        q_pending  = 4'b0001;
        tx_allowed = 4'b1111;
        wait_start(lat);
        tsf_ticks(4);
        total++; if (busy !== 1'b1 || retry_cnt_all !== 16'h0000) begin bad++; $display("FAIL wd_early got=%0b/%h exp=1/0000", busy, retry_cnt_all); end
        tsf_ticks(1);
        tick();
        total++; if (retry_cnt_all !== 16'h0001 || cw_exp_all !== 16'h4445) begin bad++; $display("FAIL wd_timeout got=%h/%h exp=0001/4445", retry_cnt_all, cw_exp_all); end
        total++; if ({tx_success, tx_drop} !== 2'b00) begin bad++; $display("FAIL wd_timeout_pulses got=%0b exp=00", {tx_success, tx_drop}); end
        // Second exchange: tx_done lands on the same cycle the watchdog expires.
        wait_start(lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL wd_regrant_latency got=%0d exp=2", lat); end
        tsf_ticks(4);
        tsf_pulse_1M = 1'b1;
        tick();
        tsf_pulse_1M = 1'b0;
        pulse_done(1'b1);
        tick();
        q_pending = 4'b0000;
        total++; if (tx_success !== 1'b1 || tx_drop !== 1'b0 || evt_qid !== 2'd0) begin bad++; $display("FAIL wd_coincide got=%0b%0b/%0d exp=10/0", tx_success, tx_drop, evt_qid); end
        total++; if (retry_cnt_all !== 16'h0000 || cw_exp_all !== 16'h4444) begin bad++; $display("FAIL wd_coincide_counters got=%h/%h exp=0000/4444", retry_cnt_all, cw_exp_all); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic seen;
        apply_reset(4'd4, 4'd10, 4'd7, 12'd0);
        q_pending  = 4'b0100;
        tx_allowed = 4'b1111;
        wait_start(lat);
        pulse_done(1'b0);
        tick();
        total++; if (retry_cnt_all !== 16'h0100) begin bad++; $display("FAIL mid_pre_retry got=%h exp=0100", retry_cnt_all); end
        wait_start(lat);
        rst       = 1'b1;
        q_pending = 4'b0000;
        tick();
        rst = 1'b0;
        pulse_done(1'b1);
        seen = tx_success | tx_drop;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | tx_success | tx_drop;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_pulse got=%0b exp=0", seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", busy); end
        total++; if (retry_cnt_all !== 16'h0000 || cw_exp_all !== 16'h4444) begin bad++; $display("FAIL mid_counters got=%h/%h exp=0000/4444", retry_cnt_all, cw_exp_all); end
        q_pending = 4'b1111;
        wait_start(lat);
        total++; if (lat !== 2 || tx_qid !== 2'd0) begin bad++; $display("FAIL mid_next_grant got=%0d/q%0d exp=2/q0", lat, tx_qid); end
        pulse_done(1'b1);
        q_pending = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_cw_clamp();
        int lat;
        logic [15:0] exp_rt [2];
        exp_rt[0] = 16'h1000; exp_rt[1] = 16'h2000;
        apply_reset(4'd8, 4'd5, 4'd7, 12'd0);
        total++; if (cw_exp_all !== 16'h5555) begin bad++; $display("FAIL clamp_reset got=%h exp=5555", cw_exp_all); end
        q_pending  = 4'b1000;
        tx_allowed = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            wait_start(lat);
            total++; if (tx_qid !== 2'd3) begin bad++; $display("FAIL clamp_qid[%0d] got=%0d exp=3", i, tx_qid); end
            pulse_done(1'b0);
            tick();
            total++; if (cw_exp_all !== 16'h5555 || retry_cnt_all !== exp_rt[i]) begin bad++; $display("FAIL clamp_fail[%0d] got=%h/%h exp=5555/%h", i, cw_exp_all, retry_cnt_all, exp_rt[i]); end
        end
        wait_start(lat);
        pulse_done(1'b1);
        tick();
        q_pending = 4'b0000;
        total++; if (cw_exp_all !== 16'h5555 || retry_cnt_all !== 16'h0000 || tx_success !== 1'b1) begin bad++; $display("FAIL clamp_success got=%h/%h/%0b exp=5555/0000/1", cw_exp_all, retry_cnt_all, tx_success); end
    endtask

    initial begin
        rst           = 1'b1;
        tsf_pulse_1M  = 1'b0;
        q_pending     = '0;
        tx_allowed    = '0;
        cw_min_exp    = 4'd4;
        cw_max_exp    = 4'd10;
        retry_limit   = 4'd7;
        tx_timeout_us = '0;
        tx_done       = 1'b0;
        tx_ack_ok     = 1'b0;
        test_reset();
        test_round_robin();
        test_backoff();
        test_retry_drop();
        test_watchdog();
        test_reset_mid();
        test_cw_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_queue_scheduler.md
TX_QUEUE_SCHEDULER -- requirements
Module: tx_queue_scheduler

Interface
REQ-001 SHALL have parameter NUM_Q, default 4, meaning the number of slices/queues; only 4 is supported.
REQ-002 SHALL have parameter CW_EXP_WIDTH, default 4, meaning the contention-window exponent width (CW = 2^exp - 1).
REQ-003 SHALL have parameter RETRY_WIDTH, default 4, meaning the retry counter width.
REQ-004 SHALL have parameter TIMEOUT_WIDTH, default 12, meaning the width of the tx watchdog in microseconds.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port tsf_pulse_1M, input, 1: one-cycle 1 us tick.
REQ-008 SHALL have port q_pending, input, 4: queue i holds a frame ready to send.
REQ-009 SHALL have port tx_allowed, input, 4: per-slice backoff-done permission from the CSMA/CA block.
REQ-010 SHALL have port cw_min_exp, input, 4: configured minimum CW exponent.
REQ-011 SHALL have port cw_max_exp, input, 4: configured maximum CW exponent.
REQ-012 SHALL have port retry_limit, input, 4: maximum retransmissions per frame.
REQ-013 SHALL have port tx_timeout_us, input, 12: watchdog for tx_done.
REQ-014 SHALL have port tx_done, input, 1: one-cycle end-of-exchange pulse from the tx engine.
REQ-015 SHALL have port tx_ack_ok, input, 1: qualifies tx_done (1 = ACK received).
REQ-016 SHALL have port tx_start, output, 1: one-cycle grant pulse to the tx engine.
REQ-017 SHALL have port tx_qid, output, 2: granted queue, held stable from tx_start until return to IDLE.
REQ-018 SHALL have port cw_exp_all, output, 16: current CW exponent of queue i in bits [4i+3:4i].
REQ-019 SHALL have port retry_cnt_all, output, 16: current retry count of queue i in bits [4i+3:4i].
REQ-020 SHALL have port tx_success, output, 1: one-cycle pulse when a frame is acknowledged.
REQ-021 SHALL have port tx_drop, output, 1: one-cycle pulse when a frame is dropped at the retry limit.
REQ-022 SHALL have port evt_qid, output, 2: queue of tx_success/tx_drop, valid only with those pulses.
REQ-023 SHALL have port busy, output, 1: high in all states except IDLE.

Function
REQ-024 SHALL implement the states IDLE, GRANT, WAIT_DONE and UPDATE.
REQ-025 In IDLE, when eligible = q_pending & tx_allowed is nonzero, SHALL select a queue round-robin, starting at last_grant+1 mod 4, register it to tx_qid and last_grant, and go to GRANT.
REQ-026 In GRANT, SHALL assert tx_start for exactly one cycle, clear the watchdog, and go to WAIT_DONE; latency from eligible to tx_start is 2 cycles.
REQ-027 In WAIT_DONE, SHALL increment the watchdog on each tsf_pulse_1M; tx_done, or watchdog == tx_timeout_us (treated as ack fail), SHALL move the block to UPDATE.
REQ-028 If tx_done and watchdog expiry coincide, SHALL let tx_done win and use its tx_ack_ok.
REQ-029 If tx_timeout_us == 0, SHALL disable the watchdog.
REQ-030 In UPDATE, on ack ok for queue q, SHALL set cw[q] = eff_min, set retry[q] = 0, and pulse tx_success.
REQ-031 In UPDATE, on ack fail with retry[q]+1 > retry_limit, SHALL set cw[q] = eff_min, set retry[q] = 0, and pulse tx_drop.
REQ-032 In UPDATE, on any other ack fail, SHALL set retry[q] += 1 and cw[q] = min(cw[q]+1, cw_max_exp).
REQ-033 SHALL return from UPDATE to IDLE after one cycle.
REQ-034 SHALL compute eff_min = min(cw_min_exp, cw_max_exp); cw values SHALL never exceed cw_max_exp or wrap.
REQ-035 SHALL ignore tx_done in IDLE and GRANT.
REQ-036 SHALL ignore changes of q_pending/tx_allowed outside IDLE.
REQ-037 SHALL apply a cw_min_exp change only at the next cw reset of that queue.
REQ-038 SHALL leave the cw and retry of non-granted queues unchanged.
REQ-039 SHALL register all outputs.

Reset
REQ-040 On rst, SHALL go to IDLE and set last_grant = 3, so that queue 0 has first priority.
REQ-041 On rst, SHALL clear tx_start, tx_success, tx_drop, busy, tx_qid, evt_qid, the watchdog and all retry counters.
REQ-042 On rst, SHALL load every cw[i] with eff_min.
REQ-043 Reset asserted in any state, including mid-WAIT_DONE, SHALL abort with no success/drop pulse.

Structure
REQ-044 SHALL place NUM_Q, the state encoding and the field widths in a shared package, xpu_sched_pkg.
REQ-045 SHALL implement the round-robin selection as the sub-module rr_arbiter4: combinational, with a 4-bit request, a 2-bit pointer, and outputs grant id and grant valid.

Verification
REQ-046 After rst with cw_min_exp=4 and cw_max_exp=10, drive q_pending=4'b1111 and tx_allowed=4'b1111 across four consecutive exchanges with ack ok -> grants are 0,1,2,3, and each tx_start is 2 cycles after eligible.
REQ-047 For queue 2 with cw_min_exp=4, cw_max_exp=6 and retry_limit=7, apply 3 failed acks -> cw_exp_all[11:8] goes 5,6,6 and retry goes 1,2,3.
REQ-048 With retry_limit=2, apply 3 failed acks on queue 1 -> tx_drop with evt_qid=1 on the third fail, cw reset to 4 and retry reset to 0.
REQ-049 With tx_timeout_us=5 and no tx_done -> UPDATE as a fail after the 5th tick; then tx_done coincident with expiry and tx_ack_ok=1 -> tx_success.
REQ-050 Assert rst in WAIT_DONE, then deliver tx_done -> no pulses, busy=0, counters cleared, and the next grant is queue 0.
REQ-051 With cw_min_exp=8 and cw_max_exp=5 -> all cw_exp_all fields equal 5 after reset and never exceed 5.
